pattern_scan_engine: RTL

Parametrised bit-pattern search accelerator for the data-memory test programs. On a start pulse it reads a PAT_W-bit pattern and an NBYTES-byte string from data memory and computes three match counts: within-byte, bytes-with-hit and byte-crossing. It writes the three counts back to consecutive memory words, then raises done. It sits beside the core as a second master on the data memory `dm1` port.

---
 rtl/pattern_scan_engine.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/pattern_scan_engine.sv
// Bit-pattern search engine: reads a pattern and a byte string from memory, counts matches, writes counts back.
// Build with PATSCAN_CROSS_EN defined to include the byte-crossing (cts) counter; otherwise cts is written as 0.
module pattern_scan_engine #(
  parameter int PAT_W    = 5,
  parameter int NBYTES   = 32,
  parameter int AW       = 8,
  parameter int STR_BASE = 0,
  parameter int PAT_ADDR = 32,
  parameter int RES_BASE = 33
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  output logic          mem_wen,
  output logic [7:0]    mem_wdata
);

  localparam int CW = $clog2(8 * NBYTES + 1);
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_PAT, SCAN, DRAIN, WR_CTB, WR_CTO, WR_CTS, DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   idx_reg;
  logic [PAT_W-1:0] pat_reg;
  logic [CW-1:0]   ctb_reg, cto_reg;
  logic [7:0]      int_hit;
  logic [3:0]      int_cnt;
  logic [7:0]      cts_wdata;
  logic            start_accept;
  logic            eval_en;

  function automatic logic [3:0] pop8(input logic [7:0] v);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 0; i < 8; i++) s = s + {3'b000, v[i]};
    return s;
  endfunction

  function automatic logic [7:0] sat8(input logic [CW-1:0] v);
    logic [CW+7:0] w;
    w = {8'h00, v};
    if (|w[CW+7:8]) return 8'hFF;
    return w[7:0];
  endfunction

  assign start_accept = start && (state_reg == IDLE || state_reg == DONE);
  // rdata holds string byte idx-1 during SCAN (idx>0) and the last byte during DRAIN
  assign eval_en = (state_reg == SCAN && idx_reg != '0) || (state_reg == DRAIN);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_int
      if (gi <= 8 - PAT_W) begin : g_win
        assign int_hit[gi] = (mem_rdata[gi+PAT_W-1:gi] == pat_reg);
      end else begin : g_none
        assign int_hit[gi] = 1'b0;
      end
    end
  endgenerate

  assign int_cnt = pop8(int_hit);

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    mem_addr   = '0;
    mem_wen    = 1'b0;
    mem_wdata  = 8'h00;
    case (state_reg)
      IDLE: if (start_accept) state_next = LOAD_PAT;
      LOAD_PAT: begin
        busy       = 1'b1;
        mem_addr   = AW'(PAT_ADDR);
        state_next = SCAN;
      end
      SCAN: begin
        busy     = 1'b1;
        mem_addr = AW'(STR_BASE) + AW'(idx_reg);
        if (idx_reg == LAST_IDX) state_next = DRAIN;
      end
      DRAIN: begin
        busy       = 1'b1;
        state_next = WR_CTB;
      end
      WR_CTB: begin
        busy       = 1'b1;
        mem_addr   = AW'(RES_BASE);
        mem_wen    = 1'b1;
        mem_wdata  = sat8(ctb_reg);
        state_next = WR_CTO;
      end
      WR_CTO: begin
        busy       = 1'b1;
        mem_addr   = AW'(RES_BASE + 1);
        mem_wen    = 1'b1;
        mem_wdata  = sat8(cto_reg);
        state_next = WR_CTS;
      end
      WR_CTS: begin
        busy       = 1'b1;
        mem_addr   = AW'(RES_BASE + 2);
        mem_wen    = 1'b1;
        mem_wdata  = cts_wdata;
        state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start_accept) state_next = LOAD_PAT;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || start_accept) begin
      idx_reg <= '0;
      pat_reg <= '0;
      ctb_reg <= '0;
      cto_reg <= '0;
    end else begin
      if (state_reg == SCAN && idx_reg != LAST_IDX) idx_reg <= idx_reg + 1'b1;
      // pattern read issued in LOAD_PAT returns during the first SCAN cycle
      if (state_reg == SCAN && idx_reg == '0) pat_reg <= mem_rdata[7:8-PAT_W];
      if (eval_en) begin
        ctb_reg <= ctb_reg + CW'(int_cnt);
        cto_reg <= cto_reg + CW'(|int_hit);
      end
    end
  end

`ifdef PATSCAN_CROSS_EN
  logic [PAT_W-2:0] tail_reg;
  logic [CW-1:0]    cts_reg;
  logic [PAT_W+6:0] comb_bits;
  logic [7:0]       cross_hit;
  logic [3:0]       cross_cnt;
  logic             first_byte;

  // previous byte's trailing bits precede the new byte in the MSB-first stream
  assign comb_bits  = {tail_reg, mem_rdata};
  assign first_byte = (state_reg == SCAN && idx_reg == IW'(1)) ||
                      (state_reg == DRAIN && NBYTES == 1);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_cross
      if (gi >= 9 - PAT_W) begin : g_win
        assign cross_hit[gi] = (comb_bits[gi+PAT_W-1:gi] == pat_reg);
      end else begin : g_none
        assign cross_hit[gi] = 1'b0;
      end
    end
  endgenerate

  assign cross_cnt = pop8(cross_hit);

  always_ff @(posedge clk) begin
    if (reset || start_accept) begin
      tail_reg <= '0;
      cts_reg  <= '0;
    end else if (eval_en) begin
      tail_reg <= mem_rdata[PAT_W-2:0];
      cts_reg  <= cts_reg + CW'(int_cnt) + CW'(first_byte ? 4'd0 : cross_cnt);
    end
  end

  assign cts_wdata = sat8(cts_reg);
`else
  assign cts_wdata = 8'h00;
`endif

endmodule
